ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 2500, sets the clk25 cycles ps2_clk is held low before the start bit (100 us at 25 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 375000, sets the clk25 cycles allowed from clock release to ACK completion (15 ms).
REQ-003 clk25  input  1  system clock; the only clock in the block.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tx_data  input  8  command byte to send to the keyboard.
REQ-006 tx_valid  input  1  request; tx_data is captured when tx_valid=1 and tx_ready=1 in the same cycle.
REQ-007 tx_ready  output  1  high only in IDLE.
REQ-008 tx_done  output  1  one-cycle pulse when the device ACKs and both lines have returned high.
REQ-009 tx_error  output  1  one-cycle pulse on NACK or timeout.
REQ-010 busy  output  1  high in every state other than IDLE; the PS/2 receiver uses it to ignore traffic.
REQ-011 ps2_clk_in, ps2_data_in  input  1 each  raw pad levels, asynchronous.
REQ-012 ps2_clk_oe, ps2_data_oe  output  1 each  open-drain controls; 1 drives the pad low, 0 releases it.

Function
REQ-013 ps2_clk_in and ps2_data_in pass through 2-flop synchronizers; a device falling edge is synchronized-clock 1 in the previous cycle and 0 in the current cycle.
REQ-014 States: IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-015 IDLE -> INHIBIT on accept: latch tx_data, compute odd parity (parity bit = ~^tx_data), set ps2_clk_oe=1, clear the cycle counter.
REQ-016 INHIBIT lasts exactly INHIBIT_CYCLES cycles.
REQ-017 In the last INHIBIT cycle, set ps2_data_oe=1 (start bit 0); ps2_clk_oe drops to 0 one cycle later; enter START.
REQ-018 START: on the 1st falling edge, drive bit0 (ps2_data_oe = ~bit) and enter DATA.
REQ-019 DATA: falling edges 2..8 drive bits 1..7, LSB first, using a 3-bit index that stops at 7 and does not wrap; the 9th falling edge drives the parity bit and enters PARITY.
REQ-020 PARITY: the 10th falling edge releases data (stop bit) and enters STOP.
REQ-021 STOP: the 11th falling edge samples synchronized data; 0 = ACK, go to WAIT_IDLE; 1 = NACK, pulse tx_error, go to IDLE.
REQ-022 WAIT_IDLE: when synchronized clock and data are both 1, pulse tx_done and go to IDLE.
REQ-023 ACK is a pass-through state reserved for the timeout path; it performs no line actions.
REQ-024 Falling edges seen in IDLE or INHIBIT are ignored.
REQ-025 tx_valid is ignored while busy=1; no queueing.
REQ-026 tx_done and tx_error are never asserted in the same cycle.
REQ-027 On every return to IDLE, both _oe outputs are 0.

Reset
REQ-028 While rst_n=0: state=IDLE; tx_ready=1; busy=0; tx_done=0; tx_error=0; ps2_clk_oe=0; ps2_data_oe=0; counters, shift register and synchronizers = 0 except synchronizers, which = 1 (idle bus).
REQ-029 Reset asserted mid-frame releases both lines asynchronously in the same cycle and emits no done/error pulse.

Configuration
REQ-030 Macro PS2_TX_TIMEOUT_EN, when defined, compiles in a watchdog counting from START entry.
REQ-031 With the watchdog, reaching TIMEOUT_CYCLES in START..WAIT_IDLE releases both lines, pulses tx_error, and returns to IDLE.
REQ-032 Without PS2_TX_TIMEOUT_EN, there is no watchdog, TIMEOUT_CYCLES is unused, and a missing device clock leaves the block in START indefinitely.

Structure
REQ-033 Shared package ps2_pkg holds the state enumeration, the PS2_FRAME_BITS=11 constant and the default cycle constants.
REQ-034 One sub-module, ps2_sync_edge, provides the 2-flop synchronizer and falling-edge detector; it is instantiated twice, with the data edge output unused.

Verification
REQ-035 Device model ACKs; send 0xED -> ps2_clk_oe low for 2500 cycles; bits observed on the device rising edge = 0,1,0,1,1,0,1,1,1 (LSB first, parity 1); stop=1; tx_done pulses exactly once.
REQ-036 Send 0x00 -> parity bit 1; send 0xFF -> parity bit 1; send 0x01 -> parity bit 0.
REQ-037 Device leaves data high at the 11th edge (NACK) -> tx_error one pulse, no tx_done, tx_ready=1 next cycle.
REQ-038 With PS2_TX_TIMEOUT_EN, the device never clocks -> tx_error exactly 375000 cycles after START entry, both _oe=0; without the macro -> busy stays 1.
REQ-039 rst_n pulsed low after the 5th falling edge -> both _oe=0 immediately; a fresh 0xF4 then completes normally with tx_done.
REQ-040 tx_valid held high with new data during a frame -> only the first byte is transmitted; the second is accepted only after tx_ready returns to 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 host transmitter:
//   ps2_state_e            - host-to-device transmit FSM states
//   PS2_FRAME_BITS         - start + 8 data + parity + stop bits
//   DEFAULT_INHIBIT_CYCLES - 100 us of clock inhibit at 25 MHz
//   DEFAULT_TIMEOUT_CYCLES - 15 ms frame watchdog at 25 MHz
//   odd_parity()           - parity bit that makes data plus parity odd
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_ACK       = 3'd6,
        ST_WAIT_IDLE = 3'd7
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS         = 11;
    localparam int unsigned DEFAULT_INHIBIT_CYCLES = 2500;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 375000;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge
// Two-flop synchronizer for one raw PS/2 pad level plus a falling-edge
// detector on the synchronized value. All flops reset to 1, the level of an
// idle open-drain bus, so reset release never produces a false edge.
//   clk_i   in  system clock
//   rst_ni  in  asynchronous active-low reset
//   d_i     in  raw asynchronous pad level
//   sync_o  out synchronized level
//   fall_o  out 1 for one cycle when sync_o was 1 last cycle and is 0 now
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// PS/2 host-to-device command transmitter. Accepts one byte, inhibits the bus
// by holding the clock low, presents the start bit, then shifts data (LSB
// first), odd parity and the stop bit on device clock falling edges, and
// finally checks the device ACK bit.
//
// Optional feature: define PS2_TX_TIMEOUT_EN to compile in a watchdog that
// aborts a frame TIMEOUT_CYCLES cycles after START entry if it has not
// completed. Without it TIMEOUT_CYCLES is unused and a silent device leaves
// the block waiting in START.
//
// Ports
//   clk25                    in  system clock (25 MHz nominal)
//   rst_n                    in  asynchronous active-low reset
//   tx_data[7:0]             in  command byte
//   tx_valid                 in  request; accepted when tx_valid & tx_ready
//   tx_ready                 out high only in IDLE
//   tx_done                  out one-cycle pulse: device ACKed, bus idle again
//   tx_error                 out one-cycle pulse: NACK or watchdog timeout
//   busy                     out high in every state except IDLE
//   ps2_clk_in, ps2_data_in  in  raw pad levels (asynchronous)
//   ps2_clk_oe, ps2_data_oe  out open-drain enables, 1 pulls the pad low
//   state_dbg                out current FSM state
//
// Handshake: a byte transfers on a rising clk25 edge where tx_valid and
// tx_ready are both 1; tx_valid while busy is ignored, nothing is queued.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output ps2_state_e state_dbg
);

    // One counter serves the inhibit interval and, when compiled in, the
    // watchdog, so it is sized for the larger of the two.
    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    // Data goes low in the last inhibit cycle so the start bit is already on
    // the bus when the clock is released.
    localparam int unsigned INH_DATA_AT = (INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0;
    localparam int unsigned INH_LAST    = (INHIBIT_CYCLES >= 1) ? INHIBIT_CYCLES - 1 : 0;

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [2:0]       idx_q, idx_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic clk_sync;
    logic clk_fall;
    logic data_sync;
    logic data_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk_i  (clk25),
        .rst_ni (rst_n),
        .d_i    (ps2_clk_in),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk_i  (clk25),
        .rst_ni (rst_n),
        .d_i    (ps2_data_in),
        .sync_o (data_sync),
        .fall_o (data_fall_unused)
    );

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            idx_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            idx_q     <= idx_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        idx_d     = idx_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    shift_d   = tx_data;
                    par_d     = odd_parity(tx_data);
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    cnt_d     = '0;
                    idx_d     = '0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q >= CNT_W'(INH_DATA_AT)) begin
                    data_oe_d = 1'b1;
                end
                if (cnt_q == CNT_W'(INH_LAST)) begin
                    clk_oe_d = 1'b0;
                    cnt_d    = '0;   // watchdog origin is START entry
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (clk_fall) begin
                    data_oe_d = ~shift_q[0];
                    idx_d     = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (clk_fall) begin
                    if (idx_q == 3'd7) begin
                        data_oe_d = ~par_q;
                        state_d   = ST_PARITY;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        data_oe_d = ~shift_q[idx_q + 3'd1];
                    end
                end
            end
            ST_PARITY: begin
                if (clk_fall) begin
                    data_oe_d = 1'b0;   // stop bit: released line reads 1
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_fall) begin
                    if (!data_sync) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        err_d     = 1'b1;
                        clk_oe_d  = 1'b0;
                        data_oe_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_ACK: begin
                // Not entered by the normal frame; only the watchdog window
                // covers it. Falls straight through.
                state_d = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_d    = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog overrides any frame progress in the same cycle, so done
        // and error can never coincide.
        if (state_q != ST_IDLE && state_q != ST_INHIBIT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                done_d    = 1'b0;
                err_d     = 1'b1;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        end
`endif
    end

    assign tx_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign tx_done     = done_q;
    assign tx_error    = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with an open-drain keyboard model that
// clocks the bus, samples bits on its rising clock edge and ACKs or NACKs.
// Frames are captured as {stop, parity, data[7:0], start}.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    ps2_state_e state_dbg;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;

    // Wired-AND bus: either side can pull low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #20 clk25 = ~clk25;

    ps2_host_tx dut (
        .clk25       (clk25),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .busy        (busy),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .state_dbg   (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    logic err_prev = 1'b0;
    logic ready_after_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk25 cycle; everything is sampled on the falling edge.
    task automatic tick();
        @(negedge clk25);
        if (err_prev) ready_after_err = tx_ready;
        err_prev = tx_error;
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) both_cnt++;
    endtask

    task automatic clear_counts();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic send(input logic [7:0] b);
        for (int i = 0; i < 100 && !tx_ready; i++) tick();
        chk("ready_before_send", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_release(output int low_cycles, output logic start_bit);
        low_cycles = 0;
        for (int i = 0; i < 20 && !ps2_clk_oe; i++) tick();
        while (ps2_clk_oe && low_cycles < 6000) begin
            low_cycles++;
            tick();
        end
        repeat (4) tick();
        start_bit = ps2_data_in;
    endtask

    task automatic dev_pulse(output logic sample);
        dev_clk = 1'b0;
        repeat (15) tick();
        dev_clk = 1'b1;
        sample = ps2_data_in;
        repeat (15) tick();
    endtask

    task automatic run_frame(input logic ack, output logic [10:0] seen, output int low_cycles);
        logic s;
        logic start_bit;
        wait_release(low_cycles, start_bit);
        seen[0] = start_bit;
        for (int i = 1; i <= 10; i++) begin
            dev_pulse(s);
            seen[i] = s;
        end
        if (ack) dev_data = 1'b0;
        repeat (5) tick();
        dev_pulse(s);
        dev_data = 1'b1;
        repeat (20) tick();
    endtask

    logic [10:0] seen;
    int          low;
    int          n;
    logic        s;
    logic        sb;

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_tx_error", 32'(tx_error), 32'd0);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // 0xED with ACK: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1
        clear_counts();
        send(8'hED);
        chk("ed_busy", 32'(busy), 32'd1);
        run_frame(1'b1, seen, low);
        chk("ed_inhibit_len", 32'(low), 32'd2500);
        chk("ed_frame", 32'(seen), 32'h7DA);
        chk("ed_done_pulses", 32'(done_cnt), 32'd1);
        chk("ed_err_pulses", 32'(err_cnt), 32'd0);
        chk("ed_idle_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("ed_idle_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("ed_ready", 32'(tx_ready), 32'd1);

        // Parity corner bytes
        clear_counts();
        send(8'h00);
        run_frame(1'b1, seen, low);
        chk("b00_frame", 32'(seen), 32'h600);
        chk("b00_parity", 32'(seen[9]), 32'd1);
        chk("b00_done", 32'(done_cnt), 32'd1);

        clear_counts();
        send(8'hFF);
        run_frame(1'b1, seen, low);
        chk("bff_frame", 32'(seen), 32'h7FE);
        chk("bff_parity", 32'(seen[9]), 32'd1);

        clear_counts();
        send(8'h01);
        run_frame(1'b1, seen, low);
        chk("b01_frame", 32'(seen), 32'h402);
        chk("b01_parity", 32'(seen[9]), 32'd0);
        chk("b01_done", 32'(done_cnt), 32'd1);

        // NACK: device leaves data high at the 11th edge
        clear_counts();
        ready_after_err = 1'b0;
        send(8'h12);
        run_frame(1'b0, seen, low);
        chk("nack_frame", 32'(seen), 32'h624);
        chk("nack_err_pulses", 32'(err_cnt), 32'd1);
        chk("nack_done_pulses", 32'(done_cnt), 32'd0);
        chk("nack_ready_next", 32'(ready_after_err), 32'd1);
        chk("nack_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("nack_data_oe", 32'(ps2_data_oe), 32'd0);

        // Reset after the 5th falling edge (bit4 of 0x0F is 0 -> data pulled low)
        clear_counts();
        send(8'h0F);
        wait_release(low, sb);
        for (int i = 0; i < 5; i++) dev_pulse(s);
        chk("mid_data_oe_before_rst", 32'(ps2_data_oe), 32'd1);
        #5;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("mid_rst_ready", 32'(tx_ready), 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("mid_rst_no_pulses", 32'(done_cnt + err_cnt), 32'd0);

        clear_counts();
        send(8'hF4);
        run_frame(1'b1, seen, low);
        chk("f4_frame", 32'(seen), 32'h5E8);
        chk("f4_done", 32'(done_cnt), 32'd1);
        chk("f4_err", 32'(err_cnt), 32'd0);

        // tx_valid held high with new data during a frame
        clear_counts();
        for (int i = 0; i < 100 && !tx_ready; i++) tick();
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        tick();
        tx_data  = 8'hAA;
        run_frame(1'b1, seen, low);
        chk("hold_first_frame", 32'(seen), 32'h6AA);
        chk("hold_first_done", 32'(done_cnt), 32'd1);
        chk("hold_second_accepted", 32'(busy), 32'd1);
        tx_valid = 1'b0;
        clear_counts();
        run_frame(1'b1, seen, low);
        chk("hold_second_frame", 32'(seen), 32'h754);
        chk("hold_second_done", 32'(done_cnt), 32'd1);

        // Silent device
        clear_counts();
        send(8'h10);
`ifdef PS2_TX_TIMEOUT_EN
        for (int i = 0; i < 3000 && state_dbg != ST_START; i++) tick();
        chk("to_start_seen", 32'(state_dbg), 32'(ST_START));
        n = 0;
        while (!tx_error && n < 400000) begin
            tick();
            n++;
        end
        chk("to_latency", 32'(n), 32'd375000);
        chk("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("to_data_oe", 32'(ps2_data_oe), 32'd0);
        tick();
        chk("to_ready", 32'(tx_ready), 32'd1);
`else
        repeat (3000) tick();
        chk("silent_busy", 32'(busy), 32'd1);
        chk("silent_state", 32'(state_dbg), 32'(ST_START));
        chk("silent_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("silent_no_err", 32'(err_cnt), 32'd0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
`endif

        chk("done_err_overlap", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
